byte_striping: RTL and testbench

Transmit-side counterpart of the byte-joining stage. It accepts a serial byte stream, one byte per `clk1Mhz` cycle when valid, and stripes consecutive bytes round-robin across four 8-bit lanes (byte 0 to Lane_0 through byte 3 to Lane_3). It presents each completed 4-byte group coherently on the lane outputs with a one-cycle strobe. A flush request closes a partial group by padding the unused slots, so the joining stage always receives whole groups.

---
 rtl/byte_striping.sv | 80 ++++++++
 tb/tb_byte_striping.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/byte_striping.sv
// Stripes a byte stream round-robin across four lanes. Each completed (or flushed and
// padded) 4-byte group is presented on Lane_0..Lane_3 together with a one-cycle strobe.
//
// state | meaning
// IDLE  | ctr_3 == 0, nothing buffered
// FILL  | 1-3 bytes buffered in sh[], waiting for the rest of the group or a flush
module byte_striping #(
    parameter logic [7:0] PAD = 8'hBC
) (
    input  logic       clk1Mhz,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       flush,
    output logic [7:0] Lane_0,
    output logic [7:0] Lane_1,
    output logic [7:0] Lane_2,
    output logic [7:0] Lane_3,
    output logic       lanes_valid,
    output logic [1:0] ctr_3,
    output logic [7:0] word_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0] state;
    logic [7:0] sh     [4];
    logic [7:0] lane_r [4];
    logic [7:0] group  [4];
    logic [2:0] post_cnt;
    logic       emit;

    // Bytes held after this edge's accept; 4 means the group is complete.
    assign post_cnt = {1'b0, ctr_3} + {2'b00, valid_in};
    assign emit     = (post_cnt == 3'd4) || (flush && ((state == FILL) || valid_in));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            group[k] = PAD;
            if (valid_in && (2'(k) == ctr_3))
                group[k] = data_in;
            else if (3'(k) < post_cnt)
                group[k] = sh[k];
        end
    end

    always_ff @(posedge clk1Mhz or negedge reset_L) begin
        if (!reset_L) begin
            state       <= IDLE;
            ctr_3       <= 2'b00;
            lanes_valid <= 1'b0;
            word_count  <= 8'h00;
            for (int k = 0; k < 4; k++) begin
                sh[k]     <= 8'h00;
                lane_r[k] <= 8'h00;
            end
        end else begin
            lanes_valid <= emit;
            if (valid_in)
                sh[ctr_3] <= data_in;
            if (emit) begin
                for (int k = 0; k < 4; k++)
                    lane_r[k] <= group[k];
                word_count <= word_count + 8'd1;
                ctr_3      <= 2'b00;
                state      <= IDLE;
            end else if (valid_in) begin
                ctr_3 <= ctr_3 + 2'd1;
                state <= FILL;
            end
        end
    end

    assign Lane_0 = lane_r[0];
    assign Lane_1 = lane_r[1];
    assign Lane_2 = lane_r[2];
    assign Lane_3 = lane_r[3];

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: a queue-based group model checked every cycle,
// plus literal expectations for each test-plan scenario.
module tb_byte_striping;

    logic       clk1Mhz = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] Lane_0, Lane_1, Lane_2, Lane_3;
    logic       lanes_valid;
    logic [1:0] ctr_3;
    logic [7:0] word_count;

    byte_striping #(.PAD(8'hBC)) dut (
        .clk1Mhz(clk1Mhz), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .flush(flush), .Lane_0(Lane_0), .Lane_1(Lane_1), .Lane_2(Lane_2), .Lane_3(Lane_3),
        .lanes_valid(lanes_valid), .ctr_3(ctr_3), .word_count(word_count)
    );

    always #500 clk1Mhz = ~clk1Mhz;

    int n_pass  = 0;
    int n_total = 0;
    int strobes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: buffered bytes in a queue; a group leaves when 4 are held or a flush arrives.
    logic [7:0] m_buf[$];
    logic [7:0] m_lane[4];
    logic       m_lv;
    int         m_groups;

    always @(posedge clk1Mhz or negedge reset_L) begin
        if (!reset_L) begin
            m_buf.delete();
            m_lane   = '{8'h00, 8'h00, 8'h00, 8'h00};
            m_lv     = 1'b0;
            m_groups = 0;
        end else begin
            if (valid_in) m_buf.push_back(data_in);
            m_lv = 1'b0;
            if (m_buf.size() == 4 || (flush && m_buf.size() > 0)) begin
                for (int k = 0; k < 4; k++)
                    m_lane[k] = (k < m_buf.size()) ? m_buf[k] : 8'hBC;
                m_buf.delete();
                m_lv = 1'b1;
                m_groups++;
            end
        end
    end

    always @(negedge clk1Mhz) begin
        chk("lane0", Lane_0, m_lane[0]);
        chk("lane1", Lane_1, m_lane[1]);
        chk("lane2", Lane_2, m_lane[2]);
        chk("lane3", Lane_3, m_lane[3]);
        chk("lanes_valid", lanes_valid, m_lv);
        chk("ctr_3", ctr_3, m_buf.size());
        chk("word_count", word_count, m_groups % 256);
        if (lanes_valid) strobes++;
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic f);
        valid_in = v;
        data_in  = d;
        flush    = f;
        @(posedge clk1Mhz);
        #1;
    endtask

    task automatic chk_lanes(input string name, input logic [31:0] exp);
        chk(name, {Lane_0, Lane_1, Lane_2, Lane_3}, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk1Mhz);
        #1;
        chk_lanes("reset_lanes", 32'h0);
        chk("reset_ctr", ctr_3, 0);
        chk("reset_wc", word_count, 0);
        reset_L = 1'b1;
        cyc(0, 8'h00, 0);

        // Continuous stream 00..0F
        strobes = 0;
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0);
        cyc(0, 8'h00, 0);
        chk("cont_strobes", strobes, 4);
        chk_lanes("cont_last", 32'h0C0D0E0F);
        chk("cont_wc", word_count, 4);
        chk("cont_ctr", ctr_3, 0);

        // Gapped stream
        cyc(1, 8'hA1, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 8'hA2, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        cyc(1, 8'hA3, 0); cyc(0, 0, 0); cyc(0, 0, 0);
        chk_lanes("gap_hold", 32'h0C0D0E0F);
        cyc(1, 8'hA4, 0);
        chk("gap_strobe", lanes_valid, 1);
        chk_lanes("gap_group", 32'hA1A2A3A4);
        cyc(0, 0, 0);
        chk("gap_strobe_off", lanes_valid, 0);

        // Flush partial
        cyc(1, 8'h11, 0); cyc(1, 8'h22, 0);
        chk_lanes("flush_hidden", 32'hA1A2A3A4);
        cyc(0, 0, 1);
        chk_lanes("flush_group", 32'h1122BCBC);
        chk("flush_strobe", lanes_valid, 1);
        chk("flush_ctr", ctr_3, 0);
        cyc(0, 0, 0);
        chk("flush_strobe_off", lanes_valid, 0);

        // Flush with accept at slot 2
        cyc(1, 8'h44, 0); cyc(1, 8'h55, 0); cyc(1, 8'h33, 1);
        chk_lanes("flush_acc", 32'h445533BC);
        // Flush with accept at slot 3: normal group only
        cyc(1, 8'h61, 0); cyc(1, 8'h62, 0); cyc(1, 8'h63, 0); cyc(1, 8'h64, 1);
        chk_lanes("flush_full", 32'h61626364);
        cyc(0, 0, 0);
        chk("flush_full_single", lanes_valid, 0);
        // Flush in IDLE
        cyc(0, 0, 1);
        chk("flush_idle", lanes_valid, 0);
        chk("wc_after_flush", word_count, 8);

        // Reset mid-group
        cyc(1, 8'h77, 0); cyc(1, 8'h78, 0);
        #100 reset_L = 1'b0;
        #1;
        chk_lanes("rst_lanes", 32'h0);
        chk("rst_ctr", ctr_3, 0);
        chk("rst_wc", word_count, 0);
        @(posedge clk1Mhz);
        #1 reset_L = 1'b1;
        cyc(0, 0, 0);

        // Wrap: 256 groups
        strobes = 0;
        for (int i = 0; i < 1024; i++) cyc(1, 8'(i * 7), 0);
        cyc(0, 0, 0);
        chk("wrap_strobes", strobes, 256);
        chk("wrap_wc", word_count, 0);
        chk("wrap_ctr", ctr_3, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
